gpa_fhdo_multi_iface: RTL

Parametrised successor of the single-board GPA-FHDO SPI interface. It accepts 32-bit command words from the gradient sequencer into an internal FIFO and serialises each word as one SPI frame to one of `N_CH` DAC80504-class boards over a shared SCLK/SDO bus with per-board chip selects. It also captures SDI readback and, when a word requests it, generates a timed LDAC pulse after the frame. It sits between the gradient data path and the off-board DACs, replacing the fixed 4-channel, single-CS, unbuffered interface.

---
 rtl/gpa_fhdo_multi_iface.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/gpa_fhdo_multi_iface.sv
// gpa_fhdo_multi_iface: buffered multi-board SPI serialiser for GPA-FHDO DAC boards.
// Command words are queued in a small FIFO. Each word becomes one SPI frame on the
// shared SCLK/SDO bus, addressed through a per-board chip select. SDI readback is
// captured per frame, and an optional timed LDAC pulse follows the frame.
module gpa_fhdo_multi_iface #(
    parameter int N_CH       = 4,
    parameter int SPI_W      = 24,
    parameter int DIV_W      = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int LDAC_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_i,
    input  logic             valid_i,
    input  logic [DIV_W-1:0] spi_clk_div_i,
    output logic             busy_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             fhd_clk_o,
    output logic             fhd_sdo_o,
    output logic [N_CH-1:0]  fhd_csn_o,
    input  logic             fhd_sdi_i,
    output logic             fhd_ldacn_o,
    output logic [SPI_W-1:0] rdata_o,
    output logic             rdata_valid_o
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WORD_W = SPI_W + 1 + CH_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HP_W   = $clog2(2 * SPI_W);
    localparam int LD_W   = (LDAC_LEN > 1) ? $clog2(LDAC_LEN) : 1;

    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [HP_W-1:0] LAST_HP  = HP_W'(2 * SPI_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;

    // ---------------- command FIFO ----------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_nxt;
    logic              push, pop;
    logic [WORD_W-1:0] head;
    logic [SPI_W-1:0]  head_pl;
    logic              head_flag;
    logic [CH_W-1:0]   head_idx;
    logic              idx_ok;
    logic [N_CH-1:0]   cs_sel;

    // ---------------- engine state ----------------
    state_t            state;
    logic [DIV_W-1:0]  div_q, tick;
    logic [HP_W-1:0]   hp;
    logic [LD_W-1:0]   ld_cnt;
    logic [SPI_W-1:0]  tx_sh, rx_sh;
    logic              flag_q;
    logic              hold_done, ldac_done, eng_nxt;

    // Bits above the command fields carry nothing for this block.
    generate
        if (WORD_W < 32) begin : g_spare
            logic unused_bits;
            assign unused_bits = ^data_i[31:WORD_W];
        end
    endgenerate

    // full_o is registered, so a word arriving while full is dropped even if a pop
    // frees a slot in the same cycle.
    assign push      = valid_i && !full_o;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = mem[rd_ptr];
    assign head_pl   = head[SPI_W-1:0];
    assign head_flag = head[SPI_W];
    assign head_idx  = head[SPI_W+1 +: CH_W];
    assign idx_ok    = (32'(head_idx) < 32'(N_CH));

    assign hold_done = (state == HOLD) && (tick == '0);
    assign ldac_done = (state == LDAC) && (ld_cnt == '0);
    // Engine will be away from IDLE next cycle.
    assign eng_nxt   = (state == IDLE) ? (pop && idx_ok)
                                       : !((hold_done && !flag_q) || ldac_done);

    // Next FIFO occupancy; a push and pop together cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    // One-hot select of the chip select addressed by the head word.
    always_comb begin
        cs_sel = '0;
        for (int i = 0; i < N_CH; i++)
            cs_sel[i] = (32'(head_idx) == i);
    end

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i[WORD_W-1:0];
    end

    // FIFO pointers, occupancy, full flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_o <= (count_nxt == FULL_CNT);
            if (valid_i && full_o)
                overflow_o <= 1'b1;
        end
    end

    // Frame engine: pop, CS setup, 2*SPI_W SCLK half-periods, CS hold, optional LDAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fhd_clk_o     <= 1'b1;
            fhd_sdo_o     <= 1'b0;
            fhd_csn_o     <= '1;
            fhd_ldacn_o   <= 1'b1;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            div_q         <= '0;
            tick          <= '0;
            hp            <= '0;
            ld_cnt        <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            flag_q        <= 1'b0;
        end else begin
            rdata_valid_o <= 1'b0;
            busy_o        <= (count_nxt != '0) || eng_nxt;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_sh  <= head_pl;
                        flag_q <= head_flag;
                        div_q  <= spi_clk_div_i;
                        tick   <= spi_clk_div_i;
                        // Out-of-range board indices are consumed without a frame.
                        if (idx_ok) begin
                            fhd_csn_o <= ~cs_sel;
                            fhd_sdo_o <= head_pl[SPI_W-1];
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (tick != '0) begin
                        tick <= tick - 1'b1;
                    end else begin
                        // First falling edge; readback is sampled on every fall.
                        tick      <= div_q;
                        hp        <= '0;
                        fhd_clk_o <= 1'b0;
                        rx_sh     <= {rx_sh[SPI_W-2:0], fhd_sdi_i};
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick != '0) begin
                        tick <= tick - 1'b1;
                    end else begin
                        tick <= div_q;
                        if (hp == LAST_HP) begin
                            fhd_csn_o     <= '1;
                            fhd_sdo_o     <= 1'b0;
                            rdata_o       <= rx_sh;
                            rdata_valid_o <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            hp        <= hp + 1'b1;
                            fhd_clk_o <= ~fhd_clk_o;
                            if (fhd_clk_o) begin
                                rx_sh <= {rx_sh[SPI_W-2:0], fhd_sdi_i};
                            end else if (hp != LAST_HP - 1'b1) begin
                                // Rising edge: present the next bit, except after the last.
                                fhd_sdo_o <= tx_sh[SPI_W-2];
                                tx_sh     <= tx_sh << 1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick != '0) begin
                        tick <= tick - 1'b1;
                    end else if (flag_q) begin
                        fhd_ldacn_o <= 1'b0;
                        ld_cnt      <= LD_W'(LDAC_LEN - 1);
                        state       <= LDAC;
                    end else begin
                        state <= IDLE;
                    end
                end
                LDAC: begin
                    if (ld_cnt != '0) begin
                        ld_cnt <= ld_cnt - 1'b1;
                    end else begin
                        fhd_ldacn_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
